// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// the zero-register index and the bundled stall/flush control word.
package pipe_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_MEM_WAIT = 2'd1;
  localparam state_t ST_FLUSH    = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic redirect;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE      = 7'b000_0000;
  localparam ctrl_t CTRL_ALL_STALL = 7'b110_1010;
  localparam ctrl_t CTRL_RESET     = 7'b001_0100;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; cleared by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use, taken
// branch, jump and data-memory wait handling, plus saturating debug counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             redirect,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       fsm_state
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t     state, nxt_state;
  logic [2:0] flush_left, nxt_left;
  logic       pend_redirect, nxt_pend;
  logic       load_use;
  logic       eval_run, take_branch;
  logic       stall_inc, flush_inc;
  ctrl_t      ctl;

  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  always_comb begin
    ctl         = CTRL_NONE;
    nxt_state   = state;
    nxt_left    = flush_left;
    nxt_pend    = pend_redirect;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    eval_run    = 1'b0;
    take_branch = 1'b0;

    case (state)
      ST_MEM_WAIT: begin
        if (mem_busy) begin
          ctl       = CTRL_ALL_STALL;
          stall_inc = 1'b1;
        end else if (pend_redirect) begin
          take_branch = 1'b1;
          nxt_pend    = 1'b0;
        end else begin
          eval_run = 1'b1;
        end
      end
      ST_FLUSH: begin
        // A branch seen here is already a bubble, so only mem_busy matters.
        if (mem_busy) begin
          ctl       = CTRL_ALL_STALL;
          stall_inc = 1'b1;
        end else begin
          ctl.if_id_flush = 1'b1;
          if (flush_left <= 3'd1) begin
            nxt_state = ST_RUN;
            nxt_left  = 3'd0;
          end else begin
            nxt_left = flush_left - 3'd1;
          end
        end
      end
      default: eval_run = 1'b1;
    endcase

    if (eval_run) begin
      nxt_state = ST_RUN;
      if (mem_busy) begin
        ctl       = CTRL_ALL_STALL;
        stall_inc = 1'b1;
        nxt_pend  = ex_branch_taken;
        nxt_state = ST_MEM_WAIT;
      end else if (ex_branch_taken) begin
        take_branch = 1'b1;
      end else if (load_use) begin
        ctl.pc_stall    = 1'b1;
        ctl.if_id_stall = 1'b1;
        ctl.id_ex_flush = 1'b1;
        stall_inc       = 1'b1;
      end else if (id_jump) begin
        ctl.if_id_flush = 1'b1;
        flush_inc       = 1'b1;
      end
    end

    if (take_branch) begin
      ctl.redirect    = 1'b1;
      ctl.if_id_flush = 1'b1;
      ctl.id_ex_flush = 1'b1;
      flush_inc       = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        nxt_state = ST_FLUSH;
        nxt_left  = FLUSH_INIT;
      end else begin
        nxt_state = ST_RUN;
        nxt_left  = 3'd0;
      end
    end

    // Reset forces bubbles into both front-end registers.
    if (!rst_n) begin
      ctl = CTRL_RESET;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RUN;
      flush_left    <= 3'd0;
      pend_redirect <= 1'b0;
    end else begin
      state         <= nxt_state;
      flush_left    <= nxt_left;
      pend_redirect <= nxt_pend;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  assign pc_stall     = ctl.pc_stall;
  assign if_id_stall  = ctl.if_id_stall;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_stall  = ctl.id_ex_stall;
  assign id_ex_flush  = ctl.id_ex_flush;
  assign ex_mem_stall = ctl.ex_mem_stall;
  assign redirect     = ctl.redirect;
  assign fsm_state    = state;

endmodule
